// File: rtl/glb_load_pkg.sv
// Shared types and constants for the GLB load sequencer: FSM state encoding,
// destination codes and the one-hot GLB write-enable mapping.
package glb_load_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] DEST_IFMAP   = 2'b00;
    localparam logic [1:0] DEST_FILTER  = 2'b01;
    localparam logic [1:0] DEST_BIAS    = 2'b10;
    localparam logic [1:0] DEST_ILLEGAL = 2'b11;

    localparam logic [2:0] WE_NONE   = 3'b000;
    localparam logic [2:0] WE_IFMAP  = 3'b001;
    localparam logic [2:0] WE_FILTER = 3'b010;
    localparam logic [2:0] WE_BIAS   = 3'b100;

    function automatic logic [2:0] dest_onehot(input logic [1:0] d);
        logic [2:0] v;
        v = WE_NONE;
        case (d)
            DEST_IFMAP:  v = WE_IFMAP;
            DEST_FILTER: v = WE_FILTER;
            DEST_BIAS:   v = WE_BIAS;
            default:     v = WE_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/glb_addr_counter.sv
// Word counter for one GLB load: latches base and length, produces the
// current write address (base + cnt, wrapping) and a last-word flag.
module glb_addr_counter #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_inc,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH-1:0] i_words,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_words;
    logic [ADDR_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_words <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_base  <= i_base;
            r_words <= i_words;
            r_cnt   <= '0;
        end else if (i_inc) begin
            r_cnt   <= r_cnt + ONE;
        end
    end

    // Address arithmetic is mod 2^ADDR_WIDTH so a load may wrap past the top.
    assign o_addr = r_base + r_cnt;
    assign o_last = (r_cnt == (r_words - ONE));

endmodule

// File: rtl/glb_load_sequencer.sv
// Pops words from the link FIFO and writes them into the ifmap/filter/bias GLB.
// Optional XOR checksum of each load's words when GLB_LOAD_CHECKSUM_EN is defined.
module glb_load_sequencer
    import glb_load_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  core_clk,
    input  logic                  core_reset,
    input  logic                  start,
    input  logic [1:0]            dest,
    input  logic [ADDR_WIDTH-1:0] words_num,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic [2:0]            glb_we,
    output logic [ADDR_WIDTH-1:0] glb_addr,
    output logic [DATA_WIDTH-1:0] glb_wdata,
    output logic                  busy,
    output logic                  ifmap_done,
    output logic                  filter_done,
    output logic                  bias_done,
    output logic                  illegal_dest,
`ifdef GLB_LOAD_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic [1:0]            o_dbg_state
);

    // FIFO handshake: fifo_rdata is valid whenever fifo_rempty is low, and a
    // word is consumed on any rising edge where fifo_rinc is high.

    state_t                r_state;
    state_t                w_next;
    logic                  w_pop;
    logic                  w_start_load;
    logic                  w_start_zero;
    logic                  w_start_bad;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic [1:0]            r_dest;
    logic [2:0]            r_we;
    logic [2:0]            r_done;
    logic                  r_illegal;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    glb_addr_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_counter (
        .clk     (core_clk),
        .rst     (core_reset),
        .i_load  (w_start_load),
        .i_inc   (w_pop),
        .i_base  (base_addr),
        .i_words (words_num),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_start_load = 1'b0;
        w_start_zero = 1'b0;
        w_start_bad  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (dest == DEST_ILLEGAL) begin
                        w_start_bad = 1'b1;
                    end else if (words_num == '0) begin
                        w_start_zero = 1'b1;
                    end else begin
                        w_start_load = 1'b1;
                        w_next       = LOAD;
                    end
                end
            end
            LOAD: begin
                w_pop = !fifo_rempty;
                if (w_pop && w_last) begin
                    w_next = FLUSH;
                end
            end
            FLUSH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Write port is registered: a pop in cycle N shows up on glb_* in cycle N+1.
    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            r_dest    <= DEST_IFMAP;
            r_we      <= WE_NONE;
            r_done    <= WE_NONE;
            r_illegal <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_we      <= w_pop ? dest_onehot(r_dest) : WE_NONE;
            r_illegal <= w_start_bad;
            if (w_pop) begin
                r_addr  <= w_addr;
                r_wdata <= fifo_rdata;
            end
            if (w_start_load) begin
                r_dest <= dest;
            end
            if (w_start_zero) begin
                r_done <= dest_onehot(dest);
            end else if (r_state == FLUSH) begin
                r_done <= dest_onehot(r_dest);
            end else begin
                r_done <= WE_NONE;
            end
        end
    end

`ifdef GLB_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            r_checksum <= '0;
        end else if (w_start_load || w_start_zero) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ fifo_rdata;
        end
    end

    assign checksum = r_checksum;
`else
    // Default build carries no checksum state.
`endif

    assign fifo_rinc    = w_pop;
    assign glb_we       = r_we;
    assign glb_addr     = r_addr;
    assign glb_wdata    = r_wdata;
    assign busy         = (r_state != IDLE);
    assign ifmap_done   = r_done[0];
    assign filter_done  = r_done[1];
    assign bias_done    = r_done[2];
    assign illegal_dest = r_illegal;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/glb_load_sequencer.md
Name: glb_load_sequencer

Overview:
- Downstream of the DRAM-to-GLB interface controller, on the core clock domain.
- Pops words from the read side of the async link FIFO and writes each one into the ifmap, filter or bias GLB.
- Generates sequential GLB write addresses from a base address.
- Pulses a per-destination done once exactly words_num words have been written.

Parameters:
- ADDR_WIDTH, 20, width of GLB address and word count (covers the 221184-word conv4 filter worst case)
- DATA_WIDTH, 16, FIFO/GLB word width

Ports:
- core_clk  in  1  core clock; the only clock
- core_reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- dest  in  2  destination: 00 ifmap, 01 filter, 10 bias, 11 illegal
- words_num  in  ADDR_WIDTH  number of words to load
- base_addr  in  ADDR_WIDTH  first GLB write address
- fifo_rempty  in  1  link FIFO empty (read side)
- fifo_rdata  in  DATA_WIDTH  FIFO head word, first-word-fall-through (valid while !fifo_rempty)
- fifo_rinc  out  1  FIFO pop
- glb_we  out  3  one-hot write enable: bit0 ifmap, bit1 filter, bit2 bias
- glb_addr  out  ADDR_WIDTH  GLB write address
- glb_wdata  out  DATA_WIDTH  GLB write data
- busy  out  1  high in LOAD and FLUSH
- ifmap_done, filter_done, bias_done  out  1 each  one-cycle completion pulses
- illegal_dest  out  1  one-cycle pulse when start arrives with dest==11

Behaviour:
- Reset: state IDLE; counters and latched fields cleared; every output 0.
- Reset mid-operation aborts the load; no done pulse is produced.
- States: IDLE, LOAD, FLUSH.
- IDLE, on start:
  - dest==11: illegal_dest=1 next cycle; stay IDLE.
  - words_num==0: matching done pulses next cycle; stay IDLE; no FIFO pop.
  - Otherwise: latch dest, words_num, base_addr; clear cnt; go to LOAD.
- start is ignored outside IDLE.
- LOAD:
  - fifo_rinc = !fifo_rempty, combinational; this is the only pop condition.
  - On a pop:
    - Register glb_wdata<=fifo_rdata and glb_addr<=base_addr+cnt, mod 2^ADDR_WIDTH, wrapping silently.
    - Set glb_we<=onehot(dest); increment cnt.
    - If cnt==words_num-1, go to FLUSH.
  - No pop: glb_we<=0; address and data hold.
  - Write latency is 1 cycle after the pop.
  - Sustained rate is one word/cycle while the FIFO is non-empty; empty cycles insert bubbles.
- FLUSH:
  - The last write is on the ports this cycle; fifo_rinc=0.
  - Next cycle: go to IDLE, glb_we=0, and the matching done pulse is high for exactly 1 cycle.
  - done therefore rises 2 cycles after the last pop; a new start is accepted in that same cycle.
- Words remaining in the FIFO after words_num pops are left untouched.
- busy falls in the same cycle done rises.
- cnt is ADDR_WIDTH wide; words_num up to 2^ADDR_WIDTH-1 is supported.

Optional Feature:
- Macro GLB_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_WIDTH-1:0]: the XOR of all words written in the current load.
  - Cleared on start acceptance; valid and held from the done pulse until the next accepted start; reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package glb_load_pkg:
  - State enum (IDLE, LOAD, FLUSH).
  - Destination codes DEST_IFMAP=2'b00, DEST_FILTER=2'b01, DEST_BIAS=2'b10.
  - One-hot write-enable constants.
- Sub-module glb_addr_counter: load base / clear / increment, producing addr=base+cnt and a last flag (cnt==words_num-1).
- The FSM and write register stay in the top module.

Test Plan:
- Ifmap, no bubbles: dest=00, base=0x100, words_num=4, FIFO holds A,B,C,D.
  - glb_we=001 on 4 consecutive cycles at addresses 0x100..0x103 with data A..D.
  - ifmap_done pulses once, 2 cycles after the 4th pop; busy low in the same cycle.
- Bias with empty gaps: dest=10, words_num=3, fifo_rempty toggling every cycle.
  - Exactly 3 pops and 3 writes with glb_we=100; addresses contiguous; no write in empty cycles.
  - bias_done single pulse.
- Edge cases:
  - words_num=0, dest=01: filter_done next cycle, no fifo_rinc.
  - dest=11: illegal_dest pulse, state stays IDLE.
- Address wrap: ADDR_WIDTH=20, base=0xFFFFE, words_num=4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Reset mid-load: assert core_reset after 2 of 5 words.
  - All outputs 0 immediately; no done pulse.
  - A new load of 2 words after reset completes normally.
- Back-to-back starts:
  - start during LOAD is ignored (word count unchanged).
  - start in the done cycle is accepted.
  - With GLB_LOAD_CHECKSUM_EN, words 0x00F0, 0x0F00 → checksum=0x0FF0.
